commit_unit: RTL and testbench

//  In-order retirement stage directly downstream of reorder_buffer. Inspects the ROB head each cycle.

---
 rtl/rob_pkg.sv | 26 ++
 rtl/commit_perf_cnt.sv | 38 +++
 rtl/commit_unit.sv | 136 +++++++++++++
 tb/tb_commit_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB / commit definitions: head status encodings, commit FSM states,
// architectural register-file geometry and the default trap vector.
// Used by reorder_buffer and commit_unit so both agree on status encodings.
package rob_pkg;

  localparam int unsigned ARCH_REGS  = 32;
  localparam int unsigned ARCH_AW    = 5;
  localparam int unsigned ROB_STAT_W = 2;

  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [ROB_STAT_W-1:0] {
    ST_INVALID   = 2'b00,
    ST_PENDING   = 2'b01,
    ST_EXCEPTION = 2'b10,
    ST_DONE      = 2'b11
  } rob_status_e;

  typedef enum logic [1:0] {
    CU_IDLE    = 2'b00,
    CU_RUN     = 2'b01,
    CU_ST_WAIT = 2'b10,
    CU_FLUSH   = 2'b11
  } cu_state_e;

endpackage

// File: rtl/commit_perf_cnt.sv
// Retirement performance counters: retired-instruction and stall-cycle counts.
// Ports:
//   clk, rstn   clock, async active-low reset
//   retire_i    one instruction retired this cycle
//   stall_i     RUN cycle with a valid head that did not retire
//   retired_o   32-bit retired count (wraps)
//   stall_o     32-bit stall count (wraps)
module commit_perf_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        retire_i,
  input  logic        stall_i,
  output logic [31:0] retired_o,
  output logic [31:0] stall_o
);

  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q + 32'(retire_i);
    stall_d   = stall_q + 32'(stall_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_o = retired_q;
  assign stall_o   = stall_q;

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage behind the reorder buffer. Retires at most one
// head per cycle, maintains the retirement map, frees superseded physical
// registers, hands stores to the store buffer and turns a head exception
// into a one-cycle flush to TRAP_VEC.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   rob_empty, rob_head_*     ROB head view (status, spec, store, dst, rd, prd, pc)
//   commit_rd                 pop ROB head (combinational)
//   free_v, free_prd          superseded physical register to the free list
//   st_commit_v/st_commit_rdy store release handshake
//   rmap_raddr, rmap_rdata    retirement-map read port (combinational)
//   flush, flush_pc, epc      exception flush redirect and excepting PC
// Optional build macro COMMIT_PERF_CNT_EN adds perf_retired / perf_stall.
module commit_unit
  import rob_pkg::*;
#(
  parameter int unsigned PRF_AW   = 6,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rob_empty,
  input  logic [1:0]        rob_head_status,
  input  logic              rob_head_spec,
  input  logic              rob_head_store,
  input  logic              rob_head_dst_v,
  input  logic [4:0]        rob_head_rd,
  input  logic [PRF_AW-1:0] rob_head_prd,
  input  logic [31:0]       rob_head_pc,
  output logic              commit_rd,
  output logic              free_v,
  output logic [PRF_AW-1:0] free_prd,
  output logic              st_commit_v,
  input  logic              st_commit_rdy,
  input  logic [4:0]        rmap_raddr,
  output logic [PRF_AW-1:0] rmap_rdata,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic [31:0]       epc
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  cu_state_e         state_q;
  logic [31:0]       epc_q;
  logic [PRF_AW-1:0] rmap_q [ARCH_REGS];

  logic head_ok, head_exc, head_done, has_dst;

  // Head qualification, retirement decision and flush outputs.
  always_comb begin
    head_ok     = !rob_empty && !rob_head_spec;
    head_exc    = head_ok && (rob_status_e'(rob_head_status) == ST_EXCEPTION);
    head_done   = head_ok && (rob_status_e'(rob_head_status) == ST_DONE);
    has_dst     = rob_head_dst_v && (rob_head_rd != 5'd0);
    commit_rd   = 1'b0;
    st_commit_v = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    case (state_q)
      CU_RUN: begin
        st_commit_v = head_done && rob_head_store;
        commit_rd   = head_done && (!rob_head_store || st_commit_rdy);
      end
      // Head is held by the ROB until it retires, so only the handshake matters.
      CU_ST_WAIT: begin
        st_commit_v = 1'b1;
        commit_rd   = st_commit_rdy;
      end
      CU_FLUSH: begin
        flush    = 1'b1;
        flush_pc = TRAP_VEC;
      end
      default: ;
    endcase
    free_v   = commit_rd && has_dst;
    free_prd = free_v ? rmap_q[rob_head_rd] : '0;
    // Read-before-write: a same-cycle commit is visible only after the edge.
    rmap_rdata = ((state_q == CU_IDLE) || (rmap_raddr == 5'd0)) ? '0 : rmap_q[rmap_raddr];
  end

  // Commit FSM and excepting-PC capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CU_IDLE;
      epc_q   <= '0;
    end else begin
      case (state_q)
        CU_IDLE: state_q <= CU_RUN;
        CU_RUN: begin
          // Exception outranks the store path.
          if (head_exc) begin
            state_q <= CU_FLUSH;
            epc_q   <= rob_head_pc;
          end else if (head_done && rob_head_store && !st_commit_rdy) begin
            state_q <= CU_ST_WAIT;
          end
        end
        CU_ST_WAIT: if (st_commit_rdy) state_q <= CU_RUN;
        CU_FLUSH:   state_q <= CU_RUN;
        default:    state_q <= CU_IDLE;
      endcase
    end
  end

  // Retirement map: identity after reset, updated only on a retiring write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rmap_q[i] <= PRF_AW'(i);
      end
    end else if (free_v) begin
      rmap_q[rob_head_rd] <= rob_head_prd;
    end
  end

  assign epc = epc_q;

`ifdef COMMIT_PERF_CNT_EN
  logic perf_stall_c;
  assign perf_stall_c = (state_q == CU_RUN) && !rob_empty && !commit_rd;

  commit_perf_cnt u_perf (
    .clk       (clk),
    .rstn      (rstn),
    .retire_i  (commit_rd),
    .stall_i   (perf_stall_c),
    .retired_o (perf_retired),
    .stall_o   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed, table-driven bench for commit_unit plus hand sequences for the
// store wait, reset during store wait and (when built with the macro) perf counters.
module tb_commit_unit;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SP = 2'b01;
  localparam logic [1:0] SX = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  logic        clk, rstn;
  logic        rob_empty, rob_head_spec, rob_head_store, rob_head_dst_v;
  logic [1:0]  rob_head_status;
  logic [4:0]  rob_head_rd, rmap_raddr;
  logic [5:0]  rob_head_prd, free_prd, rmap_rdata;
  logic [31:0] rob_head_pc, flush_pc, epc;
  logic        commit_rd, free_v, st_commit_v, st_commit_rdy, flush;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  commit_unit #(.PRF_AW(6), .TRAP_VEC(32'h0000_0100)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rob_empty       (rob_empty),
    .rob_head_status (rob_head_status),
    .rob_head_spec   (rob_head_spec),
    .rob_head_store  (rob_head_store),
    .rob_head_dst_v  (rob_head_dst_v),
    .rob_head_rd     (rob_head_rd),
    .rob_head_prd    (rob_head_prd),
    .rob_head_pc     (rob_head_pc),
    .commit_rd       (commit_rd),
    .free_v          (free_v),
    .free_prd        (free_prd),
    .st_commit_v     (st_commit_v),
    .st_commit_rdy   (st_commit_rdy),
    .rmap_raddr      (rmap_raddr),
    .rmap_rdata      (rmap_rdata),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .epc             (epc)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .perf_retired    (perf_retired),
    .perf_stall      (perf_stall)
`endif
  );

  typedef struct {
    logic        empty;
    logic [1:0]  status;
    logic        spec, store, dst_v;
    logic [4:0]  rd;
    logic [5:0]  prd;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  raddr;
    logic        e_commit, e_free_v;
    logic [5:0]  e_free_prd;
    logic        e_st, e_flush;
    logic [31:0] e_flush_pc, e_epc;
    logic [5:0]  e_rdata;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rob_empty       = v.empty;
    rob_head_status = v.status;
    rob_head_spec   = v.spec;
    rob_head_store  = v.store;
    rob_head_dst_v  = v.dst_v;
    rob_head_rd     = v.rd;
    rob_head_prd    = v.prd;
    rob_head_pc     = v.pc;
    st_commit_rdy   = v.rdy;
    rmap_raddr      = v.raddr;
  endtask

  // Drive after an edge, compare at the falling edge, advance past the next edge.
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({tag, ".commit_rd"},   32'(commit_rd),   32'(v.e_commit));
    chk({tag, ".free_v"},      32'(free_v),      32'(v.e_free_v));
    chk({tag, ".free_prd"},    32'(free_prd),    32'(v.e_free_prd));
    chk({tag, ".st_commit_v"}, 32'(st_commit_v), 32'(v.e_st));
    chk({tag, ".flush"},       32'(flush),       32'(v.e_flush));
    chk({tag, ".flush_pc"},    flush_pc,         v.e_flush_pc);
    chk({tag, ".epc"},         epc,              v.e_epc);
    chk({tag, ".rmap_rdata"},  32'(rmap_rdata),  32'(v.e_rdata));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".commit_rd"},   32'(commit_rd),   32'd0);
    chk({tag, ".free_v"},      32'(free_v),      32'd0);
    chk({tag, ".st_commit_v"}, 32'(st_commit_v), 32'd0);
    chk({tag, ".flush"},       32'(flush),       32'd0);
    chk({tag, ".epc"},         epc,              32'd0);
    chk({tag, ".rmap_rdata"},  32'(rmap_rdata),  32'd0);
  endtask

  vec_t tbl [18];
  vec_t v;

  initial begin
    //          empty st  sp sto dv rd prd pc        rdy ra   cm fv fp  st fl fpc        epc        rdata
    tbl[0]  = '{1'b0, SD, 0, 0, 1, 5, 40, 32'h0,   0, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   0};
    tbl[1]  = '{1'b0, SD, 0, 0, 1, 5, 40, 32'h0,   0, 5,  1, 1, 5,  0, 0, 32'h0,   32'h0,   5};
    tbl[2]  = '{1'b1, SD, 0, 0, 1, 5, 40, 32'h0,   0, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   40};
    tbl[3]  = '{1'b0, SD, 0, 0, 1, 5, 41, 32'h0,   0, 5,  1, 1, 40, 0, 0, 32'h0,   32'h0,   40};
    tbl[4]  = '{1'b0, SD, 0, 0, 1, 0, 50, 32'h0,   0, 0,  1, 0, 0,  0, 0, 32'h0,   32'h0,   0};
    tbl[5]  = '{1'b0, SP, 0, 0, 1, 5, 42, 32'h0,   0, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[6]  = '{1'b0, SI, 0, 0, 1, 5, 42, 32'h0,   1, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[7]  = '{1'b0, SD, 1, 1, 1, 5, 42, 32'h0,   1, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[8]  = '{1'b0, SD, 1, 0, 1, 5, 42, 32'h0,   0, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[9]  = '{1'b0, SD, 0, 0, 0, 5, 42, 32'h0,   0, 5,  1, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[10] = '{1'b0, SD, 0, 1, 0, 5, 42, 32'h0,   1, 5,  1, 0, 0,  1, 0, 32'h0,   32'h0,   41};
    tbl[11] = '{1'b0, SX, 0, 1, 1, 5, 42, 32'h80,  1, 5,  0, 0, 0,  0, 0, 32'h0,   32'h0,   41};
    tbl[12] = '{1'b0, SD, 0, 0, 1, 6, 60, 32'h0,   0, 5,  0, 0, 0,  0, 1, 32'h100, 32'h80,  41};
    tbl[13] = '{1'b1, SD, 0, 0, 0, 0, 0,  32'h0,   0, 6,  0, 0, 0,  0, 0, 32'h0,   32'h80,  6};
    tbl[14] = '{1'b0, SX, 1, 0, 0, 0, 0,  32'h200, 0, 6,  0, 0, 0,  0, 0, 32'h0,   32'h80,  6};
    tbl[15] = '{1'b1, SX, 0, 0, 0, 0, 0,  32'h300, 0, 6,  0, 0, 0,  0, 0, 32'h0,   32'h80,  6};
    tbl[16] = '{1'b0, SX, 0, 0, 0, 0, 0,  32'h44,  0, 6,  0, 0, 0,  0, 0, 32'h0,   32'h80,  6};
    tbl[17] = '{1'b1, SI, 0, 0, 0, 0, 0,  32'h0,   0, 6,  0, 0, 0,  0, 1, 32'h100, 32'h44,  6};

    // Reset held: outputs quiet even with a retirable store at the head.
    rstn = 1'b0;
    v = '{1'b0, SD, 0, 1, 1, 5, 40, 32'h0, 1, 5, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    drive(v);
    #4;
    chk_all_zero("reset");
`ifdef COMMIT_PERF_CNT_EN
    chk("reset.perf_retired", perf_retired, 32'd0);
    chk("reset.perf_stall",   perf_stall,   32'd0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Store held off for three cycles, retires with rdy on the fourth.
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, SD, 0, 1, 1, 7, 33, 32'h0, 0, 7, 0, 0, 0, 1, 0, 32'h0, 32'h44, 7};
      apply($sformatf("stwait%0d", i), v);
    end
    v = '{1'b0, SD, 0, 1, 1, 7, 33, 32'h0, 1, 7, 1, 1, 7, 1, 0, 32'h0, 32'h44, 7};
    apply("stwait3", v);
    v = '{1'b1, SI, 0, 0, 0, 0, 0, 32'h0, 0, 7, 0, 0, 0, 0, 0, 32'h0, 32'h44, 33};
    apply("stwait_after", v);

    // Reset while parked in ST_WAIT.
    v = '{1'b0, SD, 0, 1, 1, 7, 20, 32'h0, 0, 7, 0, 0, 0, 1, 0, 32'h0, 32'h44, 33};
    apply("rstwait0", v);
    apply("rstwait1", v);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    v = '{1'b1, SI, 0, 0, 0, 0, 0, 32'h0, 0, 7, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    apply("post_rst_idle", v);
    v = '{1'b1, SI, 0, 0, 0, 0, 0, 32'h0, 0, 7, 0, 0, 0, 0, 0, 32'h0, 32'h0, 7};
    apply("post_rst_run", v);

`ifdef COMMIT_PERF_CNT_EN
    // Fresh reset, then 10 retirements and 3 pending stalls.
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    v = '{1'b1, SI, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    apply("perf_idle", v);
    for (int i = 0; i < 10; i++) begin
      v = '{1'b0, SD, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0};
      apply($sformatf("perf_ret%0d", i), v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, SP, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
      apply($sformatf("perf_stall%0d", i), v);
    end
    chk("perf_retired", perf_retired, 32'd10);
    chk("perf_stall",   perf_stall,   32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
